// File: rtl/fifo_read_checker_if.sv
// fifo_read_checker_if: read-side signals of the FX3 slave FIFO.
// The FIFO master drives them, and the checker only listens.
interface fifo_read_checker_if;
  logic        RD;
  logic        LastRDData;
  logic [31:0] DQ;

  modport master (
    output RD,
    output LastRDData,
    output DQ
  );

  modport slave (
    input RD,
    input LastRDData,
    input DQ
  );
endinterface

// File: rtl/fifo_read_checker.sv
// fifo_read_checker: checks FX3 read data against an incrementing sequence.
// Keeps word/packet/error statistics and captures the first bad word.
module fifo_read_checker #(
  parameter int RD_LATENCY = 2,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 PCLK,
  input  logic                 RESET,
  fifo_read_checker_if.slave   bus,
  input  logic                 Clear,
  output logic [31:0]          WordCount,
  output logic [15:0]          PacketCount,
  output logic [ERR_CNT_W-1:0] ErrorCount,
  output logic                 ErrorFlag,
  output logic [31:0]          FirstBadData,
  output logic [31:0]          FirstExpData,
  output logic [1:0]           State
);

  typedef enum logic [1:0] {
    SEED  = 2'b00,
    CHECK = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [RD_LATENCY-1:0] rd_dly;
  logic [RD_LATENCY-1:0] last_dly;
  logic [31:0]           expected;
  logic                  valid;
  logic                  eop;
  logic                  mismatch;
  logic                  capture;

  assign valid    = rd_dly[RD_LATENCY-1];
  assign eop      = valid & last_dly[RD_LATENCY-1];
  assign mismatch = valid & (state != SEED)
                  & (bus.DQ != expected);
  assign capture  = mismatch & (state == CHECK);
  assign State    = state;

  // Align RD/LastRDData with the returned data; Clear drops in-flight words
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      rd_dly   <= '0;
      last_dly <= '0;
    end else if (Clear) begin
      rd_dly   <= '0;
      last_dly <= '0;
    end else begin
      rd_dly[0]   <= bus.RD;
      last_dly[0] <= bus.LastRDData;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_dly[i]   <= rd_dly[i-1];
        last_dly[i] <= last_dly[i-1];
      end
    end
  end

  // State register
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) state <= SEED;
    else       state <= state_nxt;
  end

  // Next state: first word seeds, first mismatch latches FAULT
  always_comb begin
    state_nxt = state;
    if (Clear) begin
      state_nxt = SEED;
    end else if (valid) begin
      unique case (state)
        SEED:    state_nxt = CHECK;
        CHECK:   state_nxt = mismatch ? FAULT : CHECK;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = SEED;
      endcase
    end
  end

  // Statistics, expected value tracking and first-error capture
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      expected     <= '0;
      WordCount    <= '0;
      PacketCount  <= '0;
      ErrorCount   <= '0;
      ErrorFlag    <= 1'b0;
      FirstBadData <= '0;
      FirstExpData <= '0;
    end else if (Clear) begin
      expected     <= '0;
      WordCount    <= '0;
      PacketCount  <= '0;
      ErrorCount   <= '0;
      ErrorFlag    <= 1'b0;
      FirstBadData <= '0;
      FirstExpData <= '0;
    end else begin
      if (valid) begin
        WordCount <= WordCount + 32'd1;
        expected  <= bus.DQ + 32'd1;
      end
      if (eop) begin
        PacketCount <= PacketCount + 16'd1;
      end
      if (mismatch) begin
        ErrorFlag <= 1'b1;
        if (ErrorCount != '1) begin
          ErrorCount <= ErrorCount + 1'b1;
        end
      end
      if (capture) begin
        FirstBadData <= bus.DQ;
        FirstExpData <= expected;
      end
    end
  end

endmodule
